// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the CPU core: sequencer state encodings and defaults.
package cpu_ctrl_pkg;

    localparam logic [2:0] ST_HALTED_ENC = 3'd0;
    localparam logic [2:0] ST_RUN_ENC    = 3'd1;
    localparam logic [2:0] ST_STEP_ENC   = 3'd2;
    localparam logic [2:0] ST_DRAIN_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_HALTED = ST_HALTED_ENC,
        ST_RUN    = ST_RUN_ENC,
        ST_STEP   = ST_STEP_ENC,
        ST_DRAIN  = ST_DRAIN_ENC,
        ST_DONE   = ST_DONE_ENC
    } pipe_state_e;

    localparam int unsigned DRAIN_CYCLES_DEF = 4;
    localparam int unsigned CNT_WIDTH_DEF    = 32;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, debug run/step/halt, load-use bubbles, HALT drain.
// Optional active-cycle counter on o_cycle_cnt when PIPE_CTRL_CYCLE_CNT_EN is defined.
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_halt,
    input  logic                 i_halt_instr,
    input  logic                 i_load_use,
    input  logic                 i_branch_taken,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_id_ex_en,
    output logic                 o_ex_mem_en,
    output logic                 o_mem_wb_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_flush,
    output logic                 o_halted,
    output logic                 o_done,
    output logic                 o_step_done
`ifdef PIPE_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] o_cycle_cnt
`endif
);

    localparam int unsigned     DCW        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCW-1:0]  DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    if (DRAIN_CYCLES < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("pipeline_ctrl: DRAIN_CYCLES and CNT_WIDTH must be >= 1");
    end

    pipe_state_e    state_q;
    pipe_state_e    state_nxt;
    logic [DCW-1:0] drain_cnt_q;
    logic [DCW-1:0] drain_cnt_nxt;
    logic           halt_instr_ok;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_HALTED;
            drain_cnt_q <= '0;
            o_step_done <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            drain_cnt_q <= drain_cnt_nxt;
            o_step_done <= (state_q == ST_STEP);
        end
    end

    // Next state plus zero-latency strobes from registered state and live hazard inputs.
    always_comb begin
        state_nxt     = state_q;
        drain_cnt_nxt = drain_cnt_q;
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_en    = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_halted      = (state_q == ST_HALTED) || (state_q == ST_DONE);
        o_done        = (state_q == ST_DONE);
        // A taken branch means the HALT in ID is on the wrong path.
        halt_instr_ok = i_halt_instr && !i_branch_taken;

        unique case (state_q)
            ST_HALTED: begin
                if (i_halt) begin
                    state_nxt = ST_HALTED;
                end else if (i_run) begin
                    state_nxt = ST_RUN;
                end else if (i_step) begin
                    state_nxt = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                o_pc_en     = 1'b1;
                o_if_id_en  = 1'b1;
                o_id_ex_en  = 1'b1;
                o_ex_mem_en = 1'b1;
                o_mem_wb_en = 1'b1;
                if (i_branch_taken) begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end else if (i_load_use || i_halt_instr) begin
                    // Hold PC and the instruction in ID; drain cycle 1 for a HALT.
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                end

                if (i_halt) begin
                    state_nxt = ST_HALTED;
                end else if (halt_instr_ok) begin
                    drain_cnt_nxt = DRAIN_LOAD;
                    state_nxt     = (DRAIN_CYCLES == 1) ? ST_DONE : ST_DRAIN;
                end else if (state_q == ST_STEP) begin
                    state_nxt = ST_HALTED;
                end
            end

            ST_DRAIN: begin
                o_id_ex_en    = 1'b1;
                o_ex_mem_en   = 1'b1;
                o_mem_wb_en   = 1'b1;
                o_id_ex_flush = 1'b1;
                if (i_halt) begin
                    state_nxt = ST_HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt_q - DCW'(1);
                    if (drain_cnt_q <= DCW'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (i_run) begin
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_HALTED;
            end
        endcase
    end

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    // Counts cycles spent advancing the pipeline; restart from DONE clears it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycle_cnt <= '0;
        end else if (state_q == ST_DONE && i_run) begin
            o_cycle_cnt <= '0;
        end else if (state_q == ST_RUN || state_q == ST_STEP || state_q == ST_DRAIN) begin
            o_cycle_cnt <= o_cycle_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios then randomized commands/hazards.
module tb_pipeline_ctrl;

    localparam int unsigned DRAIN = 4;
    localparam int unsigned CW    = 32;

    logic clk = 1'b0;
    logic i_rst_n, i_run, i_step, i_halt, i_halt_instr, i_load_use, i_branch_taken;
    logic o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en;
    logic o_if_id_flush, o_id_ex_flush, o_halted, o_done, o_step_done;
`ifdef PIPE_CTRL_CYCLE_CNT_EN
    logic [CW-1:0] o_cycle_cnt;
`endif

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_run          (i_run),
        .i_step         (i_step),
        .i_halt         (i_halt),
        .i_halt_instr   (i_halt_instr),
        .i_load_use     (i_load_use),
        .i_branch_taken (i_branch_taken),
        .o_pc_en        (o_pc_en),
        .o_if_id_en     (o_if_id_en),
        .o_id_ex_en     (o_id_ex_en),
        .o_ex_mem_en    (o_ex_mem_en),
        .o_mem_wb_en    (o_mem_wb_en),
        .o_if_id_flush  (o_if_id_flush),
        .o_id_ex_flush  (o_id_ex_flush),
        .o_halted       (o_halted),
        .o_done         (o_done),
        .o_step_done    (o_step_done)
`ifdef PIPE_CTRL_CYCLE_CNT_EN
        ,
        .o_cycle_cnt    (o_cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected flags: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, halted, done, step_done}
    typedef struct packed {
        int            idx;
        logic [9:0]    flags;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushes   = 0;
    int   pops     = 0;
    int   cyc      = 0;

    // Reference model: current mode, downstream cycles still owed by a drain, pending step pulse.
    typedef enum int {M_HALTED, M_RUN, M_STEP, M_DRAIN, M_DONE} mode_e;
    mode_e         m_mode = M_HALTED;
    int            m_left = 0;
    bit            m_sd   = 1'b0;
    logic [CW-1:0] m_cnt  = '0;

    task automatic tick(input bit rst, input bit run, input bit step, input bit halt,
                        input bit hi, input bit lu, input bit br);
        exp_t  e;
        bit    act, frz, pc, ifid, down, ififl, idfl;
        mode_e nm;
        @(posedge clk);
        #1;
        i_rst_n = rst; i_run = run; i_step = step; i_halt = halt;
        i_halt_instr = hi; i_load_use = lu; i_branch_taken = br;
        e.idx = cyc;
        cyc++;
        if (!rst) begin
            m_mode = M_HALTED; m_left = 0; m_sd = 1'b0; m_cnt = '0;
            e.flags = 10'b0000000100;
            e.cnt   = '0;
        end else begin
            act  = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
            // PC/IF-ID frozen while draining, or on a load-use/HALT not overridden by a branch.
            frz  = (m_mode == M_DRAIN) || (act && !br && (lu || hi));
            down = act;
            pc   = act && !frz;
            ifid = act && !frz;
            ififl = act && (m_mode != M_DRAIN) && br;
            idfl  = act && (frz || br);
            e.flags = {pc, ifid, down, down, down, ififl, idfl,
                       (m_mode == M_HALTED) || (m_mode == M_DONE), m_mode == M_DONE, m_sd};
            e.cnt   = m_cnt;
            m_sd = (m_mode == M_STEP);
            if (act) m_cnt = m_cnt + 1;
            nm = m_mode;
            case (m_mode)
                M_HALTED: if (!halt) nm = run ? M_RUN : (step ? M_STEP : M_HALTED);
                M_RUN, M_STEP: begin
                    if (halt) nm = M_HALTED;
                    else if (hi && !br) begin
                        m_left = DRAIN - 1;
                        nm = (m_left == 0) ? M_DONE : M_DRAIN;
                    end else if (m_mode == M_STEP) nm = M_HALTED;
                end
                M_DRAIN: begin
                    if (halt) nm = M_HALTED;
                    else begin
                        m_left--;
                        if (m_left == 0) nm = M_DONE;
                    end
                end
                default: if (run) begin nm = M_RUN; m_cnt = '0; end
            endcase
            m_mode = nm;
        end
        q.push_back(e);
        pushes++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] a;
        if (q.size() > 0) begin
            e = q.pop_front();
            pops++;
            a = {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
                 o_if_id_flush, o_id_ex_flush, o_halted, o_done, o_step_done};
            checks++;
            if (a !== e.flags) begin
                failures++;
                $display("FAIL strobes cycle=%0d got=%b exp=%b", e.idx, a, e.flags);
            end
`ifdef PIPE_CTRL_CYCLE_CNT_EN
            checks++;
            if (o_cycle_cnt !== e.cnt) begin
                failures++;
                $display("FAIL cycle_cnt cycle=%0d got=%0d exp=%0d", e.idx, o_cycle_cnt, e.cnt);
            end
`endif
        end
    end

    initial begin
        i_rst_n = 1'b0; i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0;
        i_halt_instr = 1'b0; i_load_use = 1'b0; i_branch_taken = 1'b0;

        // Reset then idle: frozen, halted.
        tick(0, 0, 0, 0, 0, 0, 0);
        idle(10);

        // Run with a load-use bubble on the fifth run cycle.
        tick(1, 1, 0, 0, 0, 0, 0);
        idle(4);
        tick(1, 0, 0, 0, 0, 1, 0);
        idle(2);
        tick(1, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Three single steps from a fresh reset.
        tick(0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            tick(1, 0, 1, 0, 0, 0, 0);
            idle(3);
        end
        idle(2);

        // HALT instruction on the eighth run cycle, drain to DONE, ignore step/halt, restart.
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0, 0);
        idle(7);
        tick(1, 0, 0, 0, 1, 0, 0);
        idle(5);
        tick(1, 0, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0, 0, 0);
        idle(2);
        tick(1, 1, 0, 0, 0, 0, 0);
        idle(3);
        tick(1, 0, 0, 1, 0, 0, 0);

        // Branch overrides load-use and cancels the wrong-path HALT.
        tick(1, 1, 0, 0, 0, 0, 0);
        idle(1);
        tick(1, 0, 0, 0, 1, 1, 1);
        idle(2);

        // Reset two cycles into a drain: no DONE.
        tick(1, 0, 0, 0, 1, 0, 0);
        idle(2);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        idle(8);

        // Randomized commands and hazards.
        for (int r = 0; r < 3000; r++) begin
            tick($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9)  == 0,
                 $urandom_range(0, 7)  == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4)  == 0,
                 $urandom_range(0, 5)  == 0);
        end

        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0 || pops != pushes) begin
            failures++;
            $display("FAIL scoreboard_drain got pops=%0d left=%0d exp pops=%0d left=0",
                     pops, q.size(), pushes);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
